cheat_code_writer: RTL

- Encoder and writer side of the cheat-digit buffer.
- Takes one cheat (12-bit ROM address offset plus 8-bit replacement byte) and a slot number.
- Writes the cheat into the 120-bit digit buffer as five 8-bit character codes, one digit per cycle.
- The cheat-code decoder and the cheat UI read this buffer directly.

---
 rtl/cheat_pkg.sv | 21 ++
 rtl/cheat_nibble_encoder.sv | 13 +
 rtl/cheat_code_writer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cheat_pkg.sv
// Shared constants and state encoding for the cheat-digit buffer writer and decoder.
package cheat_pkg;

   localparam int unsigned NUM_SLOTS         = 3;
   localparam int unsigned DIGITS_PER_SLOT   = 5;
   localparam int unsigned NUM_DIGITS        = NUM_SLOTS * DIGITS_PER_SLOT;
   localparam logic [7:0]  BLANK_CODE        = 8'h02;
   localparam logic [7:0]  DIGIT_CODE_OFFSET = 8'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Byte index of digit `digit` inside slot `slot` (base byte is 5*slot).
   function automatic logic [3:0] digit_index(input logic [1:0] slot, input logic [2:0] digit);
      return 4'(slot) * 4'(DIGITS_PER_SLOT) + 4'(digit);
   endfunction

endpackage

// File: rtl/cheat_nibble_encoder.sv
// Combinational nibble-to-character-code encoder: code = (nibble + 2) << 1.
module cheat_nibble_encoder
   import cheat_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] code
);

   always_comb begin
      code = ({4'h0, nibble} + DIGIT_CODE_OFFSET) << 1;
   end

endmodule

// File: rtl/cheat_code_writer.sv
// Writes one cheat (address + data) into the 120-bit digit buffer, one digit per cycle.
// Optional `CHEAT_CLEAR_ALL_EN adds a clearAll input that blanks the whole buffer.
module cheat_code_writer
   import cheat_pkg::*;
(
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          reqValid,
   output logic          reqReady,
   input  logic          reqClear,
   input  logic [1:0]    reqSlot,
   input  logic [11:0]   reqAddress,
   input  logic [7:0]    reqData,
`ifdef CHEAT_CLEAR_ALL_EN
   input  logic          clearAll,
`endif
   output logic [119:0]  cheatDigits,
   output logic          done,
   output logic          error
);

   state_e                         state_q, state_d;
   logic [2:0]                     cnt_q, cnt_d;
   logic [1:0]                     slot_q, slot_d;
   logic [11:0]                    addr_q, addr_d;
   logic [7:0]                     data_q, data_d;
   logic                           err_q, err_d;
   logic [NUM_DIGITS-1:0][7:0]     digits_q, digits_d;

   logic [3:0]                     cur_nibble;
   logic [7:0]                     cur_code;

   always_comb begin
      case (cnt_q)
         3'd0:    cur_nibble = addr_q[11:8];
         3'd1:    cur_nibble = addr_q[7:4];
         3'd2:    cur_nibble = addr_q[3:0];
         3'd3:    cur_nibble = data_q[7:4];
         default: cur_nibble = data_q[3:0];
      endcase
   end

   cheat_nibble_encoder u_encoder (
      .nibble (cur_nibble),
      .code   (cur_code)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      slot_d   = slot_q;
      addr_d   = addr_q;
      data_d   = data_q;
      err_d    = 1'b0;
      digits_d = digits_q;

      case (state_q)
         IDLE: begin
`ifdef CHEAT_CLEAR_ALL_EN
            if (clearAll) begin
               digits_d = {NUM_DIGITS{BLANK_CODE}};
               state_d  = DONE;
            end else
`endif
            if (reqValid) begin
               slot_d = reqSlot;
               addr_d = reqAddress;
               data_d = reqData;
               if (reqSlot >= 2'(NUM_SLOTS)) begin
                  err_d = 1'b1;
               end else begin
                  // Blank the whole slot first so a half-written cheat never decodes.
                  for (int unsigned d = 0; d < DIGITS_PER_SLOT; d++) begin
                     digits_d[digit_index(reqSlot, 3'(d))] = BLANK_CODE;
                  end
                  cnt_d   = '0;
                  state_d = reqClear ? DONE : WRITE;
               end
            end
         end
         WRITE: begin
            digits_d[digit_index(slot_q, cnt_q)] = cur_code;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(DIGITS_PER_SLOT - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         slot_q   <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         digits_q <= {NUM_DIGITS{BLANK_CODE}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         slot_q   <= slot_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         err_q    <= err_d;
         digits_q <= digits_d;
      end
   end

   assign reqReady    = (state_q == IDLE);
   assign done        = (state_q == DONE);
   assign error       = err_q;
   assign cheatDigits = digits_q;

endmodule
